// File: rtl/ap_handshake_profiler_if.sv
// Bundle of monitored ap_ctrl handshakes, run control and the statistic read port.
// Pure wiring: no latency, no backpressure (the profiler observes, it never stalls).
interface ap_handshake_profiler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 4
);
    logic [NUM_CH-1:0] ch_en_i;
    logic [NUM_CH-1:0] ap_start_i;
    logic [NUM_CH-1:0] ap_ready_i;
    logic [NUM_CH-1:0] ap_done_i;
    logic [NUM_CH-1:0] ap_continue_i;
    logic              clear_i;
    logic              finish_i;
    logic              rd_en_i;
    logic [CH_W-1:0]   rd_ch_i;
    logic [2:0]        rd_sel_i;
    logic [CNT_W-1:0]  rd_data_o;
    logic              rd_valid_o;
    logic              rd_err_o;
    logic [NUM_CH-1:0] busy_vec_o;
    logic [NUM_CH-1:0] ovf_vec_o;
    logic              frozen_o;

    modport master (
        output ch_en_i, ap_start_i, ap_ready_i, ap_done_i, ap_continue_i,
        output clear_i, finish_i, rd_en_i, rd_ch_i, rd_sel_i,
        input  rd_data_o, rd_valid_o, rd_err_o, busy_vec_o, ovf_vec_o, frozen_o
    );

    modport slave (
        input  ch_en_i, ap_start_i, ap_ready_i, ap_done_i, ap_continue_i,
        input  clear_i, finish_i, rd_en_i, rd_ch_i, rd_sel_i,
        output rd_data_o, rd_valid_o, rd_err_o, busy_vec_o, ovf_vec_o, frozen_o
    );
endinterface

// File: rtl/ap_handshake_profiler.sv
// Per-channel HLS ap_ctrl profiler: transactions, latency, stall and ready statistics.
// Read port has 1-cycle latency; no backpressure, handshakes are sampled every cycle.
module ap_handshake_profiler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    ap_handshake_profiler_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  lat_q   [NUM_CH];
    logic [CNT_W-1:0]  lat_d   [NUM_CH];
    logic [CNT_W-1:0]  txn_q   [NUM_CH];
    logic [CNT_W-1:0]  txn_d   [NUM_CH];
    logic [CNT_W-1:0]  rdy_q   [NUM_CH];
    logic [CNT_W-1:0]  rdy_d   [NUM_CH];
    logic [CNT_W-1:0]  busy_q  [NUM_CH];
    logic [CNT_W-1:0]  busy_d  [NUM_CH];
    logic [CNT_W-1:0]  stall_q [NUM_CH];
    logic [CNT_W-1:0]  stall_d [NUM_CH];
    logic [CNT_W-1:0]  last_q  [NUM_CH];
    logic [CNT_W-1:0]  last_d  [NUM_CH];
    logic [CNT_W-1:0]  max_q   [NUM_CH];
    logic [CNT_W-1:0]  max_d   [NUM_CH];
    logic              comp_vld [NUM_CH];
    logic [CNT_W-1:0]  comp_lat [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              frozen_q, frozen_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d, rd_mux;
    logic              rd_valid_q;
    logic              rd_err_q, rd_err_d;
    logic              rd_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        frozen_d = bus.clear_i ? 1'b0 : (frozen_q | bus.finish_i);
        ovf_d    = ovf_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch]  = state_q[ch];
            lat_d[ch]    = lat_q[ch];
            txn_d[ch]    = txn_q[ch];
            rdy_d[ch]    = rdy_q[ch];
            busy_d[ch]   = busy_q[ch];
            stall_d[ch]  = stall_q[ch];
            last_d[ch]   = last_q[ch];
            max_d[ch]    = max_q[ch];
            comp_vld[ch] = 1'b0;
            comp_lat[ch] = '0;
            if (bus.clear_i) begin
                state_d[ch] = ST_IDLE;
                lat_d[ch]   = '0;
                txn_d[ch]   = '0;
                rdy_d[ch]   = '0;
                busy_d[ch]  = '0;
                stall_d[ch] = '0;
                last_d[ch]  = '0;
                max_d[ch]   = '0;
                ovf_d[ch]   = 1'b0;
            end else if (!frozen_q && bus.ch_en_i[ch]) begin
                if (bus.ap_ready_i[ch]) begin
                    rdy_d[ch] = sat_inc(rdy_q[ch]);
                    if (rdy_q[ch] == CNT_MAX) ovf_d[ch] = 1'b1;
                end
                case (state_q[ch])
                    ST_IDLE: begin
                        if (bus.ap_start_i[ch]) begin
                            if (bus.ap_done_i[ch]) begin
                                comp_vld[ch] = 1'b1;
                                comp_lat[ch] = CNT_W'(1);
                            end else begin
                                state_d[ch] = ST_BUSY;
                                lat_d[ch]   = CNT_W'(1);
                                busy_d[ch]  = sat_inc(busy_q[ch]);
                                if (busy_q[ch] == CNT_MAX) ovf_d[ch] = 1'b1;
                            end
                        end
                    end
                    ST_BUSY: begin
                        busy_d[ch] = sat_inc(busy_q[ch]);
                        if (busy_q[ch] == CNT_MAX) ovf_d[ch] = 1'b1;
                        // The done cycle itself counts towards the completed latency.
                        if (bus.ap_done_i[ch]) begin
                            comp_vld[ch] = 1'b1;
                            comp_lat[ch] = sat_inc(lat_q[ch]);
                        end else begin
                            lat_d[ch] = sat_inc(lat_q[ch]);
                        end
                        if (lat_q[ch] == CNT_MAX) ovf_d[ch] = 1'b1;
                    end
                    ST_DONE_WAIT: begin
                        if (bus.ap_continue_i[ch]) begin
                            state_d[ch] = ST_IDLE;
                        end else begin
                            stall_d[ch] = sat_inc(stall_q[ch]);
                            if (stall_q[ch] == CNT_MAX) ovf_d[ch] = 1'b1;
                        end
                    end
                    default: state_d[ch] = ST_IDLE;
                endcase
                if (comp_vld[ch]) begin
                    state_d[ch] = bus.ap_continue_i[ch] ? ST_IDLE : ST_DONE_WAIT;
                    txn_d[ch]   = sat_inc(txn_q[ch]);
                    if (txn_q[ch] == CNT_MAX) ovf_d[ch] = 1'b1;
                    last_d[ch]  = comp_lat[ch];
                    if (comp_lat[ch] > max_q[ch]) max_d[ch] = comp_lat[ch];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        rd_bad = 32'(bus.rd_ch_i) >= 32'(NUM_CH);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.rd_ch_i == CH_W'(ch)) begin
                case (bus.rd_sel_i)
                    3'd0: rd_mux = txn_q[ch];
                    3'd1: rd_mux = rdy_q[ch];
                    3'd2: rd_mux = busy_q[ch];
                    3'd3: rd_mux = stall_q[ch];
                    3'd4: rd_mux = last_q[ch];
                    3'd5: rd_mux = max_q[ch];
                    3'd6: rd_mux = {{(CNT_W-2){1'b0}}, state_q[ch]};
                    3'd7: rd_mux = '0;
                endcase
            end
        end
        rd_data_d = rd_data_q;
        if (bus.rd_en_i) rd_data_d = rd_bad ? '0 : rd_mux;
        rd_err_d = bus.rd_en_i & rd_bad;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                lat_q[ch]   <= '0;
                txn_q[ch]   <= '0;
                rdy_q[ch]   <= '0;
                busy_q[ch]  <= '0;
                stall_q[ch] <= '0;
                last_q[ch]  <= '0;
                max_q[ch]   <= '0;
            end
            ovf_q      <= '0;
            frozen_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                lat_q[ch]   <= lat_d[ch];
                txn_q[ch]   <= txn_d[ch];
                rdy_q[ch]   <= rdy_d[ch];
                busy_q[ch]  <= busy_d[ch];
                stall_q[ch] <= stall_d[ch];
                last_q[ch]  <= last_d[ch];
                max_q[ch]   <= max_d[ch];
            end
            ovf_q      <= ovf_d;
            frozen_q   <= frozen_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= bus.rd_en_i;
            rd_err_q   <= rd_err_d;
        end
    end

    always_comb begin
        bus.busy_vec_o = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bus.busy_vec_o[ch] = (state_q[ch] != ST_IDLE);
        end
    end

    assign bus.ovf_vec_o  = ovf_q;
    assign bus.frozen_o   = frozen_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_err_o   = rd_err_q;
endmodule

// File: tb/tb_ap_handshake_profiler.sv
// Scoreboard bench for ap_handshake_profiler: directed scenarios plus randomized traffic.
// Expected reads are queued at issue time and popped by an independent negedge monitor.
module tb_ap_handshake_profiler;
    localparam int     NUM_CH = 4;
    localparam int     CNT_W  = 8;
    localparam int     CH_W   = 4;
    localparam longint CMAX   = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ap_handshake_profiler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    ap_handshake_profiler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: unbounded counts, saturation applied only when observed.
    longint m_txn [NUM_CH];
    longint m_rdy [NUM_CH];
    longint m_busy[NUM_CH];
    longint m_stall[NUM_CH];
    longint m_last[NUM_CH];
    longint m_max [NUM_CH];
    longint m_lat [NUM_CH];
    bit     m_in  [NUM_CH];
    bit     m_wait[NUM_CH];
    bit     m_ovf [NUM_CH];
    bit     m_frozen;

    logic [CNT_W-1:0] q_d[$];
    logic             q_e[$];
    int               q_tag[$];
    int               tag = 0;
    bit               rd_issued = 1'b0;
    bit               chk_status = 1'b0;
    logic [NUM_CH-1:0] exp_busy, exp_ovf;

    function automatic logic [CNT_W-1:0] sat(input longint v);
        return CNT_W'((v > CMAX) ? CMAX : v);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_txn[ch] = 0; m_rdy[ch] = 0; m_busy[ch] = 0; m_stall[ch] = 0;
            m_last[ch] = 0; m_max[ch] = 0; m_lat[ch] = 0;
            m_in[ch] = 1'b0; m_wait[ch] = 1'b0; m_ovf[ch] = 1'b0;
        end
        m_frozen = 1'b0;
    endtask

    task automatic complete(input int ch, input longint lat);
        m_in[ch] = 1'b0;
        m_txn[ch]++;
        m_last[ch] = lat;
        if (lat > m_max[ch]) m_max[ch] = lat;
        m_wait[ch] = !bus.ap_continue_i[ch];
    endtask

    task automatic model_step();
        if (bus.clear_i) begin
            model_reset();
            return;
        end
        if (m_frozen) return;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.ch_en_i[ch]) begin
                if (bus.ap_ready_i[ch]) m_rdy[ch]++;
                if (m_wait[ch]) begin
                    if (bus.ap_continue_i[ch]) m_wait[ch] = 1'b0;
                    else m_stall[ch]++;
                end else if (m_in[ch]) begin
                    m_busy[ch]++;
                    if (bus.ap_done_i[ch]) complete(ch, m_lat[ch] + 1);
                    else m_lat[ch]++;
                end else if (bus.ap_start_i[ch]) begin
                    if (bus.ap_done_i[ch]) complete(ch, 1);
                    else begin
                        m_in[ch] = 1'b1; m_lat[ch] = 1; m_busy[ch]++;
                    end
                end
                if (m_txn[ch] > CMAX || m_rdy[ch] > CMAX || m_busy[ch] > CMAX ||
                    m_stall[ch] > CMAX || m_lat[ch] > CMAX || m_last[ch] > CMAX)
                    m_ovf[ch] = 1'b1;
            end
        end
        if (bus.finish_i) m_frozen = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        rd_issued = bus.rd_en_i;
        model_step();
        #1;
        bus.rd_en_i  = 1'b0;
        bus.clear_i  = 1'b0;
        bus.finish_i = 1'b0;
    endtask

    task automatic rd_const(input int ch, input int sel, input longint d, input bit e);
        bus.rd_en_i  = 1'b1;
        bus.rd_ch_i  = CH_W'(ch);
        bus.rd_sel_i = 3'(sel);
        q_d.push_back(CNT_W'(d));
        q_e.push_back(e);
        q_tag.push_back(tag++);
        step();
    endtask

    task automatic rd_model(input int ch, input int sel);
        longint v;
        v = 0;
        if (ch < NUM_CH) begin
            case (sel)
                0: v = m_txn[ch];
                1: v = m_rdy[ch];
                2: v = m_busy[ch];
                3: v = m_stall[ch];
                4: v = m_last[ch];
                5: v = m_max[ch];
                6: v = m_in[ch] ? 1 : (m_wait[ch] ? 2 : 0);
                default: v = 0;
            endcase
        end
        bus.rd_en_i  = 1'b1;
        bus.rd_ch_i  = CH_W'(ch);
        bus.rd_sel_i = 3'(sel);
        q_d.push_back(sat(v));
        q_e.push_back(ch >= NUM_CH);
        q_tag.push_back(tag++);
    endtask

    task automatic run_txn(input int ch, input int lat);
        bus.ap_start_i[ch] = 1'b1;
        if (lat == 1) bus.ap_done_i[ch] = 1'b1;
        step();
        bus.ap_start_i[ch] = 1'b0;
        bus.ap_done_i[ch]  = 1'b0;
        if (lat > 1) begin
            for (int i = 0; i < lat - 2; i++) step();
            bus.ap_done_i[ch] = 1'b1;
            step();
            bus.ap_done_i[ch] = 1'b0;
        end
        step();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_issued) begin
                total++;
                if (q_d.size() == 0) begin
                    bad++;
                    $display("FAIL rd_scoreboard_empty valid=%b", bus.rd_valid_o);
                end else begin
                    logic [CNT_W-1:0] d;
                    logic e;
                    int t;
                    d = q_d.pop_front(); e = q_e.pop_front(); t = q_tag.pop_front();
                    if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== d || bus.rd_err_o !== e) begin
                        bad++;
                        $display("FAIL rd#%0d valid=%b data=%0d err=%b expected valid=1 data=%0d err=%b",
                                 t, bus.rd_valid_o, bus.rd_data_o, bus.rd_err_o, d, e);
                    end
                end
            end else begin
                total++;
                if (bus.rd_valid_o !== 1'b0 || bus.rd_err_o !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_idle valid=%b err=%b expected 0 0", bus.rd_valid_o, bus.rd_err_o);
                end
            end
            if (chk_status) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    exp_busy[ch] = m_in[ch] | m_wait[ch];
                    exp_ovf[ch]  = m_ovf[ch];
                end
                total++;
                if (bus.busy_vec_o !== exp_busy || bus.ovf_vec_o !== exp_ovf || bus.frozen_o !== m_frozen) begin
                    bad++;
                    $display("FAIL status busy=%b ovf=%b frozen=%b expected busy=%b ovf=%b frozen=%b",
                             bus.busy_vec_o, bus.ovf_vec_o, bus.frozen_o, exp_busy, exp_ovf, m_frozen);
                end
            end
        end
    end

    initial begin
        bus.ch_en_i = '0; bus.ap_start_i = '0; bus.ap_ready_i = '0; bus.ap_done_i = '0;
        bus.ap_continue_i = '1; bus.clear_i = 1'b0; bus.finish_i = 1'b0;
        bus.rd_en_i = 1'b0; bus.rd_ch_i = '0; bus.rd_sel_i = '0;
        model_reset();
        #2;
        check("reset_busy_vec", bus.busy_vec_o, 0);
        check("reset_ovf_vec", bus.ovf_vec_o, 0);
        check("reset_frozen", bus.frozen_o, 0);
        check("reset_rd_valid", bus.rd_valid_o, 0);
        check("reset_rd_data", bus.rd_data_o, 0);
        check("reset_rd_err", bus.rd_err_o, 0);
        #21;
        rst_n = 1'b1;
        bus.ch_en_i = '1;
        chk_status = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // ch0: 5-cycle transaction, ready seen once
        run_txn(0, 5);
        bus.ap_ready_i[0] = 1'b1; step(); bus.ap_ready_i[0] = 1'b0;
        rd_const(0, 0, 1, 0);
        rd_const(0, 4, 5, 0);
        rd_const(0, 5, 5, 0);
        rd_const(0, 2, 5, 0);
        for (int s = 0; s < 8; s++) begin
            longint exp_v [8] = '{1, 1, 5, 0, 5, 5, 0, 0};
            rd_const(0, s, exp_v[s], 0);
        end
        rd_const(NUM_CH, 0, 0, 1);
        rd_const(15, 4, 0, 1);
        step();

        // ch1: single-cycle block, continue withheld for 3 waiting cycles
        bus.ap_continue_i[1] = 1'b0;
        bus.ap_start_i[1] = 1'b1; bus.ap_done_i[1] = 1'b1; step();
        bus.ap_start_i[1] = 1'b0; bus.ap_done_i[1] = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.ap_continue_i[1] = 1'b1; step();
        rd_const(1, 0, 1, 0);
        rd_const(1, 4, 1, 0);
        rd_const(1, 3, 3, 0);
        rd_const(1, 6, 0, 0);
        rd_const(1, 2, 0, 0);

        // ch3: latencies 7,3,9 then finish; a later transaction is ignored
        run_txn(3, 7); run_txn(3, 3); run_txn(3, 9);
        bus.finish_i = 1'b1; step();
        run_txn(3, 20);
        check("frozen_after_finish", bus.frozen_o, 1);
        rd_const(3, 0, 3, 0);
        rd_const(3, 4, 9, 0);
        rd_const(3, 5, 9, 0);
        rd_const(3, 2, 19, 0);
        rd_const(0, 0, 1, 0);
        bus.clear_i = 1'b1; step();
        check("frozen_after_clear", bus.frozen_o, 0);
        run_txn(3, 4);
        rd_const(3, 0, 1, 0);
        rd_const(3, 4, 4, 0);
        rd_const(3, 5, 4, 0);

        // ch2: latency counter saturates at 255
        bus.ap_start_i[2] = 1'b1; step(); bus.ap_start_i[2] = 1'b0;
        for (int i = 0; i < 300; i++) step();
        bus.ap_done_i[2] = 1'b1; step(); bus.ap_done_i[2] = 1'b0;
        step();
        rd_const(2, 4, 255, 0);
        rd_const(2, 5, 255, 0);
        rd_const(2, 2, 255, 0);
        rd_const(2, 0, 1, 0);
        check("ovf_vec_sat", bus.ovf_vec_o, 4'b0100);
        bus.clear_i = 1'b1; step();
        check("ovf_vec_clear", bus.ovf_vec_o, 0);
        for (int s = 0; s < 7; s++) rd_const(2, s, 0, 0);

        // asynchronous reset while ch0 is busy
        bus.ap_start_i[0] = 1'b1; step(); bus.ap_start_i[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rd_model(0, 2); step();
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_busy_vec", bus.busy_vec_o, 0);
        check("midreset_ovf_vec", bus.ovf_vec_o, 0);
        check("midreset_frozen", bus.frozen_o, 0);
        check("midreset_rd_valid", bus.rd_valid_o, 0);
        check("midreset_rd_data", bus.rd_data_o, 0);
        check("midreset_rd_err", bus.rd_err_o, 0);
        q_d.delete(); q_e.delete(); q_tag.delete();
        rd_issued = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        rd_const(0, 0, 0, 0);
        rd_const(0, 6, 0, 0);
        rd_const(0, 2, 0, 0);

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            bus.ch_en_i       = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : '1;
            bus.ap_start_i    = NUM_CH'($urandom);
            bus.ap_done_i     = NUM_CH'($urandom & $urandom);
            bus.ap_ready_i    = NUM_CH'($urandom);
            bus.ap_continue_i = ~NUM_CH'($urandom & $urandom);
            bus.clear_i       = ($urandom_range(0, 399) == 0);
            bus.finish_i      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) != 0)
                rd_model($urandom_range(0, NUM_CH), $urandom_range(0, 7));
            step();
        end
        bus.ap_start_i = '0; bus.ap_done_i = '0;
        step(); step();
        check("scoreboard_drained", q_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ap_handshake_profiler.md
Name: ap_handshake_profiler

Overview:
- Synthesizable, parametrised successor to the per-module ap_ctrl status monitors.
- Watches NUM_CH HLS block-level handshakes: ap_start, ap_ready, ap_done, ap_continue.
- Keeps per-channel transaction, latency and stall statistics in hardware.
- Statistics are readable through a registered select port, so on-chip profiling of the myproject datapath (transpose, pairwise_dist_sq_rbf, mask_and_normalize, ...) needs no testbench dump.

Parameters:
- NUM_CH, 4, number of monitored channels (1..16).
- CNT_W, 32, width of every statistic counter (8..48).
- CH_W, 4, width of rd_ch; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clock  in  1  single clock domain, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel monitor enable.
- ap_start  in  NUM_CH  per-channel ap_start.
- ap_ready  in  NUM_CH  per-channel ap_ready.
- ap_done  in  NUM_CH  per-channel ap_done.
- ap_continue  in  NUM_CH  per-channel ap_continue; tie high for non-dataflow blocks.
- clear  in  1  synchronous clear of all statistics and state.
- finish  in  1  end-of-run pulse; freezes statistics.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  channel select.
- rd_sel  in  3  statistic select.
- rd_data  out  CNT_W  read result.
- rd_valid  out  1  rd_data valid.
- rd_err  out  1  read addressed a channel >= NUM_CH.
- busy_vec  out  NUM_CH  per-channel state is not IDLE.
- ovf_vec  out  NUM_CH  sticky flag: a counter on this channel saturated.
- frozen  out  1  statistics frozen.

Behaviour:
- Reset (reset=0, asynchronous): all counters 0, all FSMs IDLE, every output 0.
- Priority, highest first: reset, clear, frozen, normal update.
- clear: takes effect on the next edge. Zeroes counters, ovf_vec and frozen; forces every FSM to IDLE; leaves read outputs untouched.
- finish=1 while not frozen: frozen=1 next cycle. Once frozen, no counter or FSM changes until clear; reads still work.
- Disabled channel (ch_en=0): FSM and counters hold. Deasserting ch_en mid-transaction freezes that channel in place.
- Per-channel FSM, states IDLE=0, BUSY=1, DONE_WAIT=2; lat is the running latency counter:
  - IDLE, ap_start=1, ap_done=0: go to BUSY, lat=1.
  - IDLE, ap_start=1, ap_done=1 (single-cycle block): the transaction completes with latency 1. Go to IDLE if ap_continue=1, else DONE_WAIT.
  - BUSY, ap_done=0: lat++.
  - BUSY, ap_done=1: completed latency = lat+1. Go to IDLE if ap_continue=1, else DONE_WAIT.
  - DONE_WAIT: stall_cycles++ each cycle ap_continue=0. When ap_continue=1, go to IDLE; that cycle is not counted.
- On every completion:
  - txn_count++.
  - last_lat = completed latency.
  - max_lat = max(max_lat, completed latency).
- ready_count: +1 every cycle ap_ready=1, in any state, independent of the FSM.
- busy_cycles: +1 every cycle the FSM is BUSY, plus the IDLE->BUSY start cycle.
- ap_done seen in IDLE without ap_start: ignored.
- Saturation:
  - Every counter, including lat, saturates at 2**CNT_W-1 and never wraps.
  - The first saturating increment sets ovf_vec[ch].
  - A completion with saturated lat records 2**CNT_W-1.
- Read port:
  - Latency is 1 cycle: rd_valid=1 exactly the cycle after rd_en=1. Back-to-back reads are allowed.
  - rd_data is sampled from the pre-update register value at the rd_en edge.
  - rd_sel map: 0 txn_count, 1 ready_count, 2 busy_cycles, 3 stall_cycles, 4 last_lat, 5 max_lat, 6 FSM state zero-extended, 7 constant 0.
  - rd_ch >= NUM_CH: rd_data=0 and rd_err=1 with rd_valid. rd_err is otherwise 0.
  - rd_data holds its value when rd_valid=0.
- Reset mid-run: all state is lost immediately; no partial transaction is recorded.

Test Plan:
- ch0, ap_continue=1: start pulse at cycle 10, ap_done at cycle 14 -> txn_count=1, last_lat=5, max_lat=5, busy_cycles=5, busy_vec[0] low from cycle 15.
- ch1: same-cycle start+done with ap_continue=0 for 3 cycles, then 1 -> txn_count=1, last_lat=1, stall_cycles=3, state reads 0 afterwards.
- ch2, CNT_W=8: hold BUSY for 300 cycles -> last_lat=255, ovf_vec[2]=1, no wrap; then clear -> all zero, ovf_vec=0.
- ch3: transactions with latencies 7, 3, 9; finish pulse, then a further 20-cycle transaction -> txn_count=3, last_lat=9, max_lat=9, frozen=1; clear then resumes counting.
- Read rd_ch=NUM_CH -> rd_valid=1, rd_err=1, rd_data=0 one cycle later. Back-to-back reads of rd_sel 0..7 return in order on consecutive cycles.
- Assert reset low while ch0 is BUSY (asynchronous, off the clock edge) -> every output 0 immediately; after release, txn_count=0.
